// File: rtl/e_stage_unit.sv
// Execute stage: ALU, RS/RT forwarding, multi-cycle MUL/DIV with HI/LO, E/M register.
// Optional overflow flag on ADD/SUB is built only when E_OVERFLOW_DETECT_EN is defined.
module e_stage_unit #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] IRE,
    input  logic [31:0] PC4E,
    input  logic [31:0] RSE,
    input  logic [31:0] RTE,
    input  logic [31:0] EXTE,
    input  logic [3:0]  ALUOp,
    input  logic        ALUSrc,
    input  logic [2:0]  MDOp,
    input  logic [1:0]  MDRead,
    input  logic [1:0]  Forward_RS_E_src,
    input  logic [1:0]  Forward_RT_E_src,
    input  logic [31:0] M_AO_FW,
    input  logic [31:0] W_RF_WD_OUT,
    output logic        Start,
    output logic        Busy,
    output logic [31:0] AOM,
    output logic [31:0] RTM,
    output logic [31:0] IRM,
    output logic [31:0] PC4M,
    output logic        OVM
);

    localparam int MAXC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int CW   = $clog2(MAXC + 1);

    logic [31:0] a, rtf, b, alu_y, res;
    logic [4:0]  shamt;
    logic        ov_d;

    logic [31:0] aom_q, rtm_q, irm_q, pc4m_q;
    logic        ovm_q;
    logic [31:0] hi_q, lo_q, hi_d, lo_d;
    logic [31:0] phi_q, plo_q, phi_d, plo_d;
    logic        pdz_q, pdz_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        busy_q;
    logic        md_op, commit;

    logic [63:0] prod_s, prod_u;
    logic [31:0] abs_a, abs_b, q_u, r_u;

    always_comb begin
        case (Forward_RS_E_src)
            2'd1:    a = M_AO_FW;
            2'd2:    a = W_RF_WD_OUT;
            default: a = RSE;
        endcase
        case (Forward_RT_E_src)
            2'd1:    rtf = M_AO_FW;
            2'd2:    rtf = W_RF_WD_OUT;
            default: rtf = RTE;
        endcase
        b     = ALUSrc ? EXTE : rtf;
        shamt = IRE[10:6];
    end

    always_comb begin
        case (ALUOp)
            4'd0:    alu_y = a + b;
            4'd1:    alu_y = a - b;
            4'd2:    alu_y = a & b;
            4'd3:    alu_y = a | b;
            4'd4:    alu_y = a ^ b;
            4'd5:    alu_y = ~(a | b);
            4'd6:    alu_y = {31'd0, $signed(a) < $signed(b)};
            4'd7:    alu_y = {31'd0, a < b};
            4'd8:    alu_y = b << shamt;
            4'd9:    alu_y = b >> shamt;
            4'd10:   alu_y = $signed(b) >>> shamt;
            4'd11:   alu_y = {b[15:0], 16'd0};
            default: alu_y = 32'd0;
        endcase
        case (MDRead)
            2'd1:    res = hi_q;
            2'd2:    res = lo_q;
            default: res = alu_y;
        endcase
    end

`ifdef E_OVERFLOW_DETECT_EN
    logic [31:0] sum_y, dif_y;
    always_comb begin
        sum_y = a + b;
        dif_y = a - b;
        ov_d  = 1'b0;
        if (ALUOp == 4'd0)
            ov_d = (a[31] == b[31]) && (sum_y[31] != a[31]);
        else if (ALUOp == 4'd1)
            ov_d = (a[31] != b[31]) && (dif_y[31] != a[31]);
    end
`else
    assign ov_d = 1'b0;
`endif

    // signed divide on magnitudes keeps INT_MIN / -1 well defined
    always_comb begin
        prod_s = {{32{a[31]}}, a} * {{32{rtf[31]}}, rtf};
        prod_u = {32'd0, a} * {32'd0, rtf};
        abs_a  = a[31] ? (32'd0 - a) : a;
        abs_b  = rtf[31] ? (32'd0 - rtf) : rtf;
        q_u    = 32'd0;
        r_u    = 32'd0;
        if (rtf != 32'd0) begin
            q_u = abs_a / abs_b;
            r_u = abs_a % abs_b;
        end
    end

    assign md_op  = (MDOp >= 3'd1) && (MDOp <= 3'd4);
    assign Start  = md_op && !busy_q;
    assign commit = (cnt_q == CW'(1));

    always_comb begin
        phi_d = phi_q;
        plo_d = plo_q;
        pdz_d = pdz_q;
        cnt_d = (cnt_q != '0) ? cnt_q - CW'(1) : '0;
        if (Start) begin
            pdz_d = 1'b0;
            case (MDOp)
                3'd1: begin
                    cnt_d = CW'(MULT_CYC);
                    {phi_d, plo_d} = prod_s;
                end
                3'd2: begin
                    cnt_d = CW'(MULT_CYC);
                    {phi_d, plo_d} = prod_u;
                end
                3'd3: begin
                    cnt_d = CW'(DIV_CYC);
                    pdz_d = (rtf == 32'd0);
                    plo_d = (a[31] ^ rtf[31]) ? (32'd0 - q_u) : q_u;
                    phi_d = a[31] ? (32'd0 - r_u) : r_u;
                end
                default: begin
                    cnt_d = CW'(DIV_CYC);
                    pdz_d = (rtf == 32'd0);
                    plo_d = (rtf != 32'd0) ? a / rtf : 32'd0;
                    phi_d = (rtf != 32'd0) ? a % rtf : 32'd0;
                end
            endcase
        end
    end

    // a commit edge takes priority over MTHI/MTLO
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (commit) begin
            if (!pdz_q) begin
                hi_d = phi_q;
                lo_d = plo_q;
            end
        end else if (MDOp == 3'd5) begin
            hi_d = a;
        end else if (MDOp == 3'd6) begin
            lo_d = a;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            aom_q  <= '0;
            rtm_q  <= '0;
            irm_q  <= '0;
            pc4m_q <= '0;
            ovm_q  <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            phi_q  <= '0;
            plo_q  <= '0;
            pdz_q  <= 1'b0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            aom_q  <= res;
            rtm_q  <= rtf;
            irm_q  <= IRE;
            pc4m_q <= PC4E;
            ovm_q  <= ov_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            phi_q  <= phi_d;
            plo_q  <= plo_d;
            pdz_q  <= pdz_d;
            cnt_q  <= cnt_d;
            busy_q <= (cnt_d != '0);
        end
    end

    assign AOM  = aom_q;
    assign RTM  = rtm_q;
    assign IRM  = irm_q;
    assign PC4M = pc4m_q;
    assign OVM  = ovm_q;
    assign Busy = busy_q;

endmodule

// File: tb/tb_e_stage_unit.sv
// Scoreboard bench for e_stage_unit: reference model pushes expected E/M
// contents per cycle, a monitor pops and compares after each rising edge.
module tb_e_stage_unit;

    logic        Clk, Reset;
    logic [31:0] IRE, PC4E, RSE, RTE, EXTE, M_AO_FW, W_RF_WD_OUT;
    logic [3:0]  ALUOp;
    logic        ALUSrc;
    logic [2:0]  MDOp;
    logic [1:0]  MDRead, FRS, FRT;
    logic        Start, Busy, OVM;
    logic [31:0] AOM, RTM, IRM, PC4M;

`ifdef E_OVERFLOW_DETECT_EN
    localparam bit OVE = 1'b1;
`else
    localparam bit OVE = 1'b0;
`endif

    e_stage_unit #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .Clk(Clk), .Reset(Reset), .IRE(IRE), .PC4E(PC4E),
        .RSE(RSE), .RTE(RTE), .EXTE(EXTE), .ALUOp(ALUOp),
        .ALUSrc(ALUSrc), .MDOp(MDOp), .MDRead(MDRead),
        .Forward_RS_E_src(FRS), .Forward_RT_E_src(FRT),
        .M_AO_FW(M_AO_FW), .W_RF_WD_OUT(W_RF_WD_OUT),
        .Start(Start), .Busy(Busy), .AOM(AOM), .RTM(RTM),
        .IRM(IRM), .PC4M(PC4M), .OVM(OVM)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] aom, rtm, irm, pc4m;
        logic        ovm, busy, st_exp, st_act;
    } rec_t;

    rec_t q[$];
    int passed = 0;
    int total  = 0;

    // reference state: architectural HI/LO plus an abstract "cycles left" timer
    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    bit          m_pok;
    int          m_left;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [31:0] fw(input logic [1:0] s, input logic [31:0] d);
        if (s == 2'd1) return M_AO_FW;
        if (s == 2'd2) return W_RF_WD_OUT;
        return d;
    endfunction

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input int sh);
        longint sa, sb, t;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return ~(a | b);
            4'd6:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd7:  return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
            4'd8:  return b << sh;
            4'd9:  return b >> sh;
            4'd10: begin t = sb >>> sh; return t[31:0]; end
            4'd11: return b * 32'd65536;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit ovf_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, r;
        sa = $signed(a);
        sb = $signed(b);
        if (op > 4'd1) return 1'b0;
        r = (op == 4'd0) ? sa + sb : sa - sb;
        return (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endfunction

    task automatic model_reset();
        m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_pok = 0; m_left = 0;
    endtask

    task automatic defaults();
        IRE = $urandom; PC4E = $urandom;
        RSE = 0; RTE = 0; EXTE = 0;
        M_AO_FW = $urandom; W_RF_WD_OUT = $urandom;
        ALUOp = 0; ALUSrc = 0; MDOp = 0; MDRead = 0; FRS = 0; FRT = 0;
    endtask

    // called just after a falling edge with inputs set; returns at next falling edge
    task automatic step();
        rec_t r;
        logic [31:0] a, rt, b;
        longint sa, sb;
        logic [63:0] pu;
        bit st, commit;
        #1;
        a  = fw(FRS, RSE);
        rt = fw(FRT, RTE);
        b  = ALUSrc ? EXTE : rt;
        r.aom = (MDRead == 2'd1) ? m_hi : (MDRead == 2'd2) ? m_lo
              : alu_ref(ALUOp, a, b, int'(IRE[10:6]));
        r.rtm = rt; r.irm = IRE; r.pc4m = PC4E;
        r.ovm = OVE ? ovf_ref(ALUOp, a, b) : 1'b0;
        st = (MDOp >= 1 && MDOp <= 4) && (m_left == 0);
        r.st_exp = st;
        r.st_act = Start;
        commit = (m_left == 1);
        if (commit) begin
            if (m_pok) begin m_hi = m_phi; m_lo = m_plo; end
        end else if (MDOp == 5) m_hi = a;
        else if (MDOp == 6) m_lo = a;
        if (st) begin
            sa = $signed(a);
            sb = $signed(rt);
            m_pok = 1;
            m_left = (MDOp <= 2) ? 5 : 10;
            case (MDOp)
                3'd1: begin pu = sa * sb; {m_phi, m_plo} = pu; end
                3'd2: begin pu = longint'(a) * longint'(rt); {m_phi, m_plo} = pu; end
                3'd3: if (rt == 0) m_pok = 0;
                      else begin
                          pu = sa / sb; m_plo = pu[31:0];
                          pu = sa % sb; m_phi = pu[31:0];
                      end
                default: if (rt == 0) m_pok = 0;
                         else begin m_plo = a / rt; m_phi = a % rt; end
            endcase
        end else if (m_left > 0) m_left--;
        r.busy = (m_left != 0);
        q.push_back(r);
        @(negedge Clk);
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) begin defaults(); step(); end
    endtask

    task automatic md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] t);
        defaults(); MDOp = op; RSE = a; RTE = t; step();
    endtask

    task automatic rd(input logic [1:0] sel, input string nm, input logic [31:0] exp);
        defaults(); MDRead = sel; step();
        chk(nm, AOM, exp);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_aom"}, AOM, 0);
        chk({nm, "_rtm"}, RTM, 0);
        chk({nm, "_irm"}, IRM, 0);
        chk({nm, "_pc4m"}, PC4M, 0);
        chk({nm, "_ovm"}, OVM, 0);
        chk({nm, "_busy"}, Busy, 0);
    endtask

    always @(posedge Clk) begin
        #1;
        if (q.size() != 0) begin
            rec_t r;
            r = q.pop_front();
            chk("start", r.st_act, r.st_exp);
            chk("aom", AOM, r.aom);
            chk("rtm", RTM, r.rtm);
            chk("irm", IRM, r.irm);
            chk("pc4m", PC4M, r.pc4m);
            chk("ovm", OVM, r.ovm);
            chk("busy", Busy, r.busy);
        end
    end

    initial begin
        Reset = 0;
        defaults();
        model_reset();
        #1 Reset = 1;
        #1 chk_zero("rst");
        @(negedge Clk);
        Reset = 0;

        defaults(); ALUOp = 0; RSE = 32'h7FFFFFFF; EXTE = 1; ALUSrc = 1; step();
        chk("add_wrap", AOM, 32'h80000000);
        chk("add_ovm", OVM, OVE);

        defaults(); FRS = 1; M_AO_FW = 5; EXTE = 3; ALUSrc = 1; step();
        chk("fwd_add", AOM, 8);

        md(3'd1, 32'hFFFFFFFE, 3);
        nop(5);
        rd(2'd1, "mult_hi", 32'hFFFFFFFF);
        rd(2'd2, "mult_lo", 32'hFFFFFFFA);

        md(3'd3, 32'hFFFFFFF9, 2);
        nop(10);
        rd(2'd2, "div_lo", 32'hFFFFFFFD);
        rd(2'd1, "div_hi", 32'hFFFFFFFF);
        md(3'd4, 7, 0);
        nop(10);
        rd(2'd1, "divz_hi", 32'hFFFFFFFF);
        rd(2'd2, "divz_lo", 32'hFFFFFFFD);

        md(3'd1, 3, 4);
        md(3'd2, 5, 6);
        nop(4);
        rd(2'd2, "ign_lo", 12);

        defaults(); MDOp = 6; RSE = 32'h1234; step();
        rd(2'd2, "mtlo", 32'h1234);

        defaults(); ALUOp = 10; RTE = 32'h80000000; IRE = 32'd4 << 6; step();
        chk("sra", AOM, 32'hF8000000);
        defaults(); ALUOp = 7; RSE = 1; RTE = 32'hFFFFFFFF; step();
        chk("sltu", AOM, 1);
        defaults(); ALUOp = 6; RSE = 1; RTE = 32'hFFFFFFFF; step();
        chk("slt", AOM, 0);

        md(3'd3, 100, 7);
        nop(6);
        chk("mid_busy", Busy, 1);
        Reset = 1;
        #1 chk_zero("midrst");
        model_reset();
        @(negedge Clk);
        Reset = 0;
        rd(2'd1, "post_rst_hi", 0);

        for (int i = 0; i < 600; i++) begin
            int k;
            defaults();
            RSE = $urandom; RTE = $urandom; EXTE = $urandom;
            k = $urandom_range(0, 5);
            if (k == 0) RSE = 32'h7FFFFFFF;
            if (k == 1) RSE = 32'h80000000;
            if (k == 2) RTE = 32'hFFFFFFFF;
            if (k == 3) RTE = $urandom_range(0, 3);
            ALUOp = 4'($urandom_range(0, 15));
            ALUSrc = 1'($urandom);
            FRS = 2'($urandom); FRT = 2'($urandom);
            MDRead = 2'($urandom);
            k = $urandom_range(0, 15);
            MDOp = (k < 8) ? 3'(k) : 3'd0;
            step();
        end
        nop(1);
        @(posedge Clk);
        #2;
        chk("queue_drained", 64'(q.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
